// File: rtl/instr_fetch.sv
// Fetch stage: issues one req/ack memory read per PC, holds the word for decode, stalls the PC until handoff.
// Latency: >=3 cycles per instruction (IDLE, WAIT, HOLD); decode backpressure holds the word and keeps pc_stall high.
module instr_fetch #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR      = '0,
  parameter int                    TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  flush,
  output logic                  pc_stall,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_instr,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic                  fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                state, state_nxt;
  logic                  imem_req_nxt;
  logic [ADDR_WIDTH-1:0] imem_addr_nxt;
  logic [ADDR_WIDTH-1:0] req_pc, req_pc_nxt;
  logic                  id_valid_nxt;
  logic [DATA_WIDTH-1:0] id_instr_nxt;
  logic [ADDR_WIDTH-1:0] id_pc_nxt;
  logic                  fetch_err_nxt;
  logic                  squash, squash_nxt;
  logic [15:0]           wait_cnt, wait_cnt_nxt;
  logic                  kill;
  logic                  timeout;

  // A redirect seen earlier in this transaction or right now discards the result.
  assign kill    = squash | flush;
  assign timeout = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      req_pc    <= '0;
      id_valid  <= 1'b0;
      id_instr  <= NOP_INSTR;
      id_pc     <= '0;
      fetch_err <= 1'b0;
      squash    <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      imem_req  <= imem_req_nxt;
      imem_addr <= imem_addr_nxt;
      req_pc    <= req_pc_nxt;
      id_valid  <= id_valid_nxt;
      id_instr  <= id_instr_nxt;
      id_pc     <= id_pc_nxt;
      fetch_err <= fetch_err_nxt;
      squash    <= squash_nxt;
      wait_cnt  <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    imem_req_nxt  = imem_req;
    imem_addr_nxt = imem_addr;
    req_pc_nxt    = req_pc;
    id_valid_nxt  = id_valid;
    id_instr_nxt  = id_instr;
    id_pc_nxt     = id_pc;
    fetch_err_nxt = fetch_err;
    squash_nxt    = squash;
    wait_cnt_nxt  = wait_cnt;

    case (state)
      IDLE: begin
        if (!flush) begin
          imem_req_nxt  = 1'b1;
          imem_addr_nxt = pc_in;
          req_pc_nxt    = pc_in;
          wait_cnt_nxt  = '0;
          state_nxt     = WAIT;
        end
      end

      WAIT: begin
        wait_cnt_nxt = wait_cnt + 16'd1;
        if (imem_ack) begin
          imem_req_nxt = 1'b0;
          squash_nxt   = 1'b0;
          if (kill) begin
            state_nxt = IDLE;
          end else begin
            id_instr_nxt = imem_rdata;
            id_pc_nxt    = req_pc;
            id_valid_nxt = 1'b1;
            state_nxt    = HOLD;
          end
        end else if (timeout) begin
          imem_req_nxt  = 1'b0;
          fetch_err_nxt = 1'b1;
          squash_nxt    = 1'b0;
          if (kill) begin
            state_nxt = IDLE;
          end else begin
            id_instr_nxt = NOP_INSTR;
            id_pc_nxt    = req_pc;
            id_valid_nxt = 1'b1;
            state_nxt    = HOLD;
          end
        end else if (flush) begin
          // The bus read cannot be aborted; remember to drop its data.
          squash_nxt = 1'b1;
        end
      end

      HOLD: begin
        if (flush || id_ready) begin
          id_valid_nxt = 1'b0;
          state_nxt    = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign pc_stall = !((state == HOLD) && id_ready && !flush && !reset);

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a PC model, a memory responder and a transaction scoreboard
// predict every registered output and pc_stall each cycle.
module tb_instr_fetch;

  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam int          TO  = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] pc_in = '0;
  logic          flush = 1'b0;
  logic          pc_stall;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          id_valid;
  logic          id_ready = 1'b0;
  logic [DW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic          fetch_err;

  instr_fetch #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .NOP_INSTR     (NOP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_in     (pc_in),
    .flush     (flush),
    .pc_stall  (pc_stall),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_instr  (id_instr),
    .id_pc     (id_pc),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: which phase of a fetch transaction the bench believes is under way
  bit          primed = 1'b0;
  bit          in_txn = 1'b0;
  bit          holding = 1'b0;
  bit          squashed = 1'b0;
  int          w = 0;
  int          ack_at = 0;
  int          next_delay = -2;
  bit          force_ack = 1'b0;
  bit          redirect_set = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc_m = '0;
  bit          e_req = 1'b0;
  logic [31:0] e_addr = '0;
  bit          e_valid = 1'b0;
  logic [31:0] e_instr = NOP;
  logic [31:0] e_pc = '0;
  bit          e_err = 1'b0;
  bit          e_stall = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int pick_delay();
    int k;
    k = int'($urandom_range(0, 7));
    if (k == 0) return 99;
    if (k == 1) return TO - 1;
    return int'($urandom_range(0, 3));
  endfunction

  // One clock cycle: f / r = 0 or 1 forces flush / id_ready, negative means random.
  task automatic step(input bit rst, input int f, input int r);
    @(negedge clk);
    pc_in = pc_m;
    reset = rst;
    if (primed) begin
      chk("imem_req",  64'(imem_req),  64'(e_req));
      chk("imem_addr", 64'(imem_addr), 64'(e_addr));
      chk("id_valid",  64'(id_valid),  64'(e_valid));
      chk("id_instr",  64'(id_instr),  64'(e_instr));
      chk("id_pc",     64'(id_pc),     64'(e_pc));
      chk("fetch_err", 64'(fetch_err), 64'(e_err));
    end
    if (rst)        flush = 1'b0;
    else if (f < 0) flush = ($urandom_range(0, 9) == 0);
    else            flush = f[0];
    id_ready = (r < 0) ? ($urandom_range(0, 9) < 6) : r[0];
    imem_ack = 1'b0;
    if (in_txn && w == ack_at) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(e_addr);
    end else if (!in_txn || rst) begin
      if (force_ack || $urandom_range(0, 7) == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
      end
    end
    force_ack = 1'b0;
    #1;
    e_stall = !(holding && id_ready && !flush && !rst);
    if (primed) chk("pc_stall", 64'(pc_stall), 64'(e_stall));

    if (rst) begin
      in_txn = 1'b0; holding = 1'b0; squashed = 1'b0;
      e_req = 1'b0; e_addr = '0; e_valid = 1'b0; e_instr = NOP; e_pc = '0; e_err = 1'b0;
      primed = 1'b1;
    end else if (holding) begin
      if (flush || id_ready) begin
        holding = 1'b0;
        e_valid = 1'b0;
      end
    end else if (in_txn) begin
      if (imem_ack || w == TO - 1) begin
        in_txn = 1'b0;
        e_req  = 1'b0;
        if (!imem_ack) e_err = 1'b1;
        if (!(squashed || flush)) begin
          holding = 1'b1;
          e_valid = 1'b1;
          e_instr = imem_ack ? imem_rdata : NOP;
          e_pc    = e_addr;
        end
      end else begin
        if (flush) squashed = 1'b1;
        w++;
      end
    end else if (!flush) begin
      in_txn = 1'b1; squashed = 1'b0; w = 0;
      e_req  = 1'b1;
      e_addr = pc_in;
      if (next_delay != -2) begin
        ack_at = next_delay;
        next_delay = -2;
      end else begin
        ack_at = pick_delay();
      end
    end

    if (!rst) begin
      if (flush) begin
        pc_m = redirect_set ? redirect_pc : $urandom;
        redirect_set = 1'b0;
      end else if (!e_stall) begin
        pc_m = pc_m + 32'd1;
      end
    end
  endtask

  task automatic go_idle();
    for (int i = 0; i < 40 && (in_txn || holding); i++) step(1'b0, 0, 1);
    chk("idle_reached", 64'(in_txn || holding), 64'(0));
  endtask

  task automatic go_hold(input int r);
    for (int i = 0; i < 40 && !holding; i++) step(1'b0, 0, r);
    chk("hold_reached", 64'(holding), 64'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset release with pc 212 and a 2-cycle memory
    pc_m = 32'd212;
    step(1'b1, 0, 1);
    step(1'b1, 0, 1);
    next_delay = 2;
    go_hold(1);
    step(1'b0, 0, 1);

    // Decode backpressure for 5 cycles, then a single handoff
    go_idle();
    next_delay = 0;
    go_hold(0);
    for (int i = 0; i < 5; i++) step(1'b0, 0, 0);
    step(1'b0, 0, 1);
    step(1'b0, 0, 1);

    // Redirect mid-WAIT: 212 fetch dropped, next request at 220
    go_idle();
    pc_m = 32'd212;
    next_delay = 4;
    step(1'b0, 0, 1);
    step(1'b0, 0, 1);
    redirect_set = 1'b1;
    redirect_pc  = 32'd220;
    step(1'b0, 1, 1);
    for (int i = 0; i < 5; i++) step(1'b0, 0, 1);

    // Redirect coinciding with ack, then redirect while holding with id_ready=1
    go_idle();
    next_delay = 1;
    step(1'b0, 0, 1);
    step(1'b0, 0, 1);
    step(1'b0, 1, 1);
    step(1'b0, 0, 0);
    go_idle();
    next_delay = 0;
    go_hold(0);
    step(1'b0, 1, 1);
    step(1'b0, 0, 1);

    // Memory never answers: timeout delivers NOP and latches fetch_err
    go_idle();
    next_delay = 99;
    go_hold(0);
    step(1'b0, 0, 1);
    for (int i = 0; i < 12; i++) step(1'b0, 0, 1);

    // Reset in the middle of WAIT with acks during and after it
    go_idle();
    next_delay = 99;
    step(1'b0, 0, 1);
    step(1'b0, 0, 1);
    step(1'b0, 0, 1);
    force_ack = 1'b1;
    step(1'b1, 0, 1);
    force_ack = 1'b1;
    step(1'b0, 0, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 0, 1);

    // Random traffic
    for (int i = 0; i < 4000; i++) step($urandom_range(0, 199) == 0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
